// File: rtl/l1_bus_issuer.sv
// L1 miss-to-bus issuer: expands miss requests into WRITE/READ/RWITM bus
// transactions, queues them and drives one per cycle on add_out/cmd_out.

module l1_bus_issuer_ctr (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [31:0] cnt
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt <= '0;
    else if (inc) cnt <= cnt + 32'd1;
  end
endmodule

module l1_bus_issuer #(
  parameter int          ADDR_W      = 26,
  parameter int          OFFSET_BITS = 6,
  parameter int          DEPTH       = 4,
  parameter logic [1:0]  READ_OUT    = 2'b01,
  parameter logic [1:0]  WRITE_OUT   = 2'b10,
  parameter logic [1:0]  RW_OUT      = 2'b11,
  parameter logic [1:0]  NOP         = 2'b00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_write,
  input  logic              req_dirty,
  input  logic [ADDR_W-1:0] req_victim_addr,
  input  logic              bus_stall,
  output logic [ADDR_W-1:0] add_out,
  output logic [1:0]        cmd_out,
  output logic              busy,
  output logic [31:0]       cnt_read,
  output logic [31:0]       cnt_write,
  output logic [31:0]       cnt_rwitm
);
  localparam int PW    = $clog2(DEPTH);
  localparam int CNT_W = PW + 1;
  localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << OFFSET_BITS;
  localparam logic [2:0][1:0]   CMD_TAB   = {RW_OUT, WRITE_OUT, READ_OUT};

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [1:0]        cmd;
  } bus_ent_t;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_HOLD} state_t;

  bus_ent_t [DEPTH-1:0] mem;
  bus_ent_t             head, wb_ent, fill_ent;
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count, n_push;
  logic                 accept, empty, pop, complete;
  state_t               state;
  logic [2:0]           ctr_inc;
  logic [2:0][31:0]     ctr_val;

  // Two free slots are required so a dirty miss always fits whole.
  assign req_ready = (count <= CNT_W'(DEPTH - 2));
  assign accept    = req_valid & req_ready;
  assign empty     = (count == '0);
  assign head      = mem[rd_ptr];
  assign complete  = (state != ST_IDLE) && !bus_stall;
  assign pop       = !empty && ((state == ST_IDLE) || !bus_stall);
  assign busy      = !empty || (cmd_out != NOP);

  always_comb begin
    wb_ent.addr   = req_victim_addr & LINE_MASK;
    wb_ent.cmd    = WRITE_OUT;
    fill_ent.addr = req_addr & LINE_MASK;
    fill_ent.cmd  = req_write ? RW_OUT : READ_OUT;
    n_push        = '0;
    if (accept) n_push = req_dirty ? CNT_W'(2) : CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      if (req_dirty) begin
        mem[wr_ptr]           <= wb_ent;
        mem[wr_ptr + PW'(1)]  <= fill_ent;
      end else begin
        mem[wr_ptr]           <= fill_ent;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + n_push[PW-1:0];
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count  <= count + n_push - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cmd_out <= NOP;
      add_out <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            add_out <= head.addr;
            cmd_out <= head.cmd;
            state   <= ST_ISSUE;
          end
        end
        default: begin
          if (bus_stall) begin
            state <= ST_HOLD;
          end else if (!empty) begin
            add_out <= head.addr;
            cmd_out <= head.cmd;
            state   <= ST_ISSUE;
          end else begin
            cmd_out <= NOP;
            state   <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // Counter 0 = READ, 1 = WRITE, 2 = RWITM.
  for (genvar i = 0; i < 3; i++) begin : g_ctr
    assign ctr_inc[i] = complete && (cmd_out == CMD_TAB[i]);
    l1_bus_issuer_ctr u_ctr (
      .clk (clk),
      .rst (rst),
      .inc (ctr_inc[i]),
      .cnt (ctr_val[i])
    );
  end

  assign cnt_read  = ctr_val[0];
  assign cnt_write = ctr_val[1];
  assign cnt_rwitm = ctr_val[2];

endmodule

// File: tb/tb_l1_bus_issuer.sv
// Directed bench for l1_bus_issuer: hand-computed bus sequences and counters.
`timescale 1ns/1ps
module tb_l1_bus_issuer;
  localparam int ADDR_W = 26;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_ready, req_write, req_dirty, bus_stall, busy;
  logic [ADDR_W-1:0] req_addr, req_victim_addr, add_out;
  logic [1:0]        cmd_out;
  logic [31:0]       cnt_read, cnt_write, cnt_rwitm;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  l1_bus_issuer dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_addr        (req_addr),
    .req_write       (req_write),
    .req_dirty       (req_dirty),
    .req_victim_addr (req_victim_addr),
    .bus_stall       (bus_stall),
    .add_out         (add_out),
    .cmd_out         (cmd_out),
    .busy            (busy),
    .cnt_read        (cnt_read),
    .cnt_write       (cnt_write),
    .cnt_rwitm       (cnt_rwitm)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic bus(input string tag, input logic [1:0] c, input logic [ADDR_W-1:0] a);
    chk({tag, ".cmd"}, 64'(cmd_out), 64'(c));
    chk({tag, ".add"}, 64'(add_out), 64'(a));
  endtask

  task automatic present(input logic [ADDR_W-1:0] a, input logic w, input logic d,
                         input logic [ADDR_W-1:0] v);
    req_valid = 1'b1; req_addr = a; req_write = w; req_dirty = d; req_victim_addr = v;
  endtask

  logic [1:0]        exp_cmd [6];
  logic [ADDR_W-1:0] exp_add [6];

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_dirty = 1'b0;
    req_victim_addr = '0; bus_stall = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst.cmd",   64'(cmd_out),   64'h0);
    chk("rst.add",   64'(add_out),   64'h0);
    chk("rst.cnt",   {cnt_read, cnt_write | cnt_rwitm}, 64'h0);
    chk("rst.busy",  64'(busy),      64'h0);
    chk("rst.ready", 64'(req_ready), 64'h1);
    rst = 1'b0;
    tick();

    // Clean read miss
    present(26'h0ABCDEF, 1'b0, 1'b0, 26'h3FFFFFF);
    tick(); req_valid = 1'b0;
    chk("rd.lat.cmd", 64'(cmd_out), 64'h0);
    chk("rd.lat.busy", 64'(busy), 64'h1);
    tick(); bus("rd.issue", 2'b01, 26'h0ABCDC0);
    tick();
    chk("rd.nop", 64'(cmd_out), 64'h0);
    chk("rd.cnt", 64'(cnt_read), 64'h1);
    chk("rd.busy", 64'(busy), 64'h0);

    // Dirty write miss
    present(26'h0000085, 1'b1, 1'b1, 26'h1000040);
    tick(); req_valid = 1'b0;
    tick(); bus("dw.wb", 2'b10, 26'h1000040);
    tick(); bus("dw.fill", 2'b11, 26'h0000080);
    tick();
    chk("dw.nop", 64'(cmd_out), 64'h0);
    chk("dw.cnts", {cnt_read, cnt_write, cnt_rwitm}, {32'd1, 32'd1, 32'd1});

    // Stall hold: WRITE stays four cycles
    present(26'h0000085, 1'b1, 1'b1, 26'h1000040);
    tick(); req_valid = 1'b0;
    tick(); bus("st.wb0", 2'b10, 26'h1000040);
    bus_stall = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick(); bus($sformatf("st.wb%0d", i), 2'b10, 26'h1000040);
      chk($sformatf("st.cnt%0d", i), 64'(cnt_write), 64'd1);
    end
    bus_stall = 1'b0;
    tick(); bus("st.fill", 2'b11, 26'h0000080);
    tick();
    chk("st.nop", 64'(cmd_out), 64'h0);
    chk("st.cnts", {cnt_read, cnt_write, cnt_rwitm}, {32'd1, 32'd2, 32'd2});

    // Fill to full with stall held
    exp_cmd = '{2'b10, 2'b01, 2'b10, 2'b11, 2'b10, 2'b01};
    exp_add = '{26'h0000100, 26'h0000200, 26'h0000300, 26'h0000400, 26'h0000500, 26'h0000640};
    bus_stall = 1'b1;
    present(26'h0000200, 1'b0, 1'b1, 26'h0000100);
    chk("ff.ready0", 64'(req_ready), 64'h1);
    tick();
    chk("ff.ready1", 64'(req_ready), 64'h1);
    present(26'h0000400, 1'b1, 1'b1, 26'h0000300);
    tick();
    present(26'h0000640, 1'b0, 1'b1, 26'h0000500);
    chk("ff.ready2", 64'(req_ready), 64'h0);
    bus("ff.e0", exp_cmd[0], exp_add[0]);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("ff.hold.ready%0d", i), 64'(req_ready), 64'h0);
      bus($sformatf("ff.hold%0d", i), exp_cmd[0], exp_add[0]);
    end
    bus_stall = 1'b0;
    for (int i = 1; i < 6; i++) begin
      tick();
      bus($sformatf("ff.e%0d", i), exp_cmd[i], exp_add[i]);
      if (i == 1) chk("ff.ready3", 64'(req_ready), 64'h1);
      if (i == 2) req_valid = 1'b0;
    end
    tick();
    chk("ff.nop", 64'(cmd_out), 64'h0);
    chk("ff.cnts", {cnt_read, cnt_write, cnt_rwitm}, {32'd3, 32'd5, 32'd3});

    // Reset while HOLD with three entries queued
    bus_stall = 1'b1;
    present(26'h0000A00, 1'b0, 1'b1, 26'h0000B00);
    tick();
    present(26'h0000C00, 1'b1, 1'b1, 26'h0000D00);
    tick(); req_valid = 1'b0;
    tick();
    bus("mr.hold", 2'b10, 26'h0000B00);
    chk("mr.ready", 64'(req_ready), 64'h0);
    #2 rst = 1'b1;
    #1;
    chk("mr.cmd", 64'(cmd_out), 64'h0);
    chk("mr.cnts", {cnt_read, cnt_write | cnt_rwitm}, 64'h0);
    chk("mr.ready1", 64'(req_ready), 64'h1);
    chk("mr.busy", 64'(busy), 64'h0);
    @(negedge clk);
    rst = 1'b0; bus_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("mr.post%0d", i), 64'(cmd_out), 64'h0);
    end

    // Counter wrap
    present(26'h0000085, 1'b1, 1'b1, 26'h1000040);
    tick(); req_valid = 1'b0;
    tick(); tick(); tick();
    force dut.g_ctr[0].u_ctr.cnt = 32'hFFFF_FFFF;
    #1 release dut.g_ctr[0].u_ctr.cnt;
    @(negedge clk);
    chk("wr.pre", 64'(cnt_read), 64'hFFFF_FFFF);
    present(26'h0000123, 1'b0, 1'b0, 26'h0);
    tick(); req_valid = 1'b0;
    tick(); bus("wr.issue", 2'b01, 26'h0000100);
    tick();
    chk("wr.cnts", {cnt_read, cnt_write, cnt_rwitm}, {32'd0, 32'd1, 32'd1});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
